fnd_scan_decoder: RTL and testbench

// - Receive-side counterpart of the FND multiplexed display driver.
// - Samples the scanned fnd_comm/fnd_font lines and filters scan glitches.
// - Decodes each digit's segment pattern back to BCD and rebuilds a full 4-digit frame.
// - Used as a bench/board monitor for the stopwatch and watch display paths (UART dump, self-check).

---
 rtl/fnd_scan_decoder.sv | 254 +++++++++++++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_decoder.sv
// -----------------------------------------------------------------------------
// fnd_scan_decoder
//
// Receive-side monitor for a multiplexed 4-digit 7-segment (FND) display.
// It watches the scanned digit-select and segment lines and filters glitches
// on them. Each digit's segment pattern is decoded back to BCD, and the four
// digits are reassembled into one frame.
//
// Parameters
//   STABLE_CYCLES   identical registered samples needed before a digit is
//                   captured (>= 1)
//   TIMEOUT_CYCLES  cycles without a completed frame before o_stale asserts
//
// Optional feature
//   BIN_OUT_EN      when defined, o_bin_hi/o_bin_lo carry the binary value of
//                   the digit pairs {d3,d2} and {d1,d0}. They are 7'h7F if
//                   either source digit failed to decode. When the macro is
//                   undefined, both ports are tied to zero.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-low reset
//   i_fnd_comm     digit select, active-low one-hot-low, bit0 = rightmost
//   i_fnd_font     segments, active-low, [6:0] = g..a, [7] = dp
//   o_frame_valid  one-cycle pulse when a new frame is presented
//   o_digits       {d3,d2,d1,d0} BCD, 4'hF for an undecodable pattern
//   o_dp           decimal point per digit, 1 = lit
//   o_seg_err      per-digit flag for a pattern outside the decode table
//   o_err_cnt      saturating count of dwells on an invalid digit select
//   o_stale        no frame completed for TIMEOUT_CYCLES
//   o_bin_hi       d3*10+d2 (BIN_OUT_EN only)
//   o_bin_lo       d1*10+d0 (BIN_OUT_EN only)
// -----------------------------------------------------------------------------
module fnd_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  i_fnd_comm,
  input  logic [7:0]  i_fnd_font,
  output logic        o_frame_valid,
  output logic [15:0] o_digits,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_seg_err,
  output logic [7:0]  o_err_cnt,
  output logic        o_stale,
  output logic [6:0]  o_bin_hi,
  output logic [6:0]  o_bin_lo
);

  localparam int SC_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 1 : 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam bit              SINGLE  = (STABLE_CYCLES <= 1);

  localparam logic [3:0] COMM_BLANK = 4'b1111;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2,
    S_BAD    = 2'd3
  } state_t;

  // Segment pattern (active-low g..a) to {seg_err, digit}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  function automatic logic comm_is_valid(input logic [3:0] c);
    return (c == 4'b1110) || (c == 4'b1101) || (c == 4'b1011) || (c == 4'b0111);
  endfunction

  function automatic logic [1:0] comm_slot(input logic [3:0] c);
    logic [1:0] r;
    case (c)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // ---- stage p0: input registers ------------------------------------------
  // The reset value is the blank (all-off) pattern, so the first cycle after
  // reset does not look like an invalid digit select.
  logic [3:0] comm_p0;
  logic [7:0] font_p0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      comm_p0 <= COMM_BLANK;
      font_p0 <= FONT_BLANK;
    end else begin
      comm_p0 <= i_fnd_comm;
      font_p0 <= i_fnd_font;
    end
  end

  // ---- stage p1: dwell FSM and slot capture -------------------------------
  state_t          state;
  logic [SC_W-1:0] stab_cnt;
  logic [3:0]      cur_comm;
  logic [7:0]      cur_font;

  logic [3:0][3:0] slot_digit;
  logic [3:0]      slot_dp;
  logic [3:0]      slot_err;
  logic [3:0]      seen;

  logic       same_p0;
  logic       entry_valid;
  logic       take_entry;
  logic       capture;
  logic       cnt_step;
  logic       frame_done;
  logic [4:0] dec_p0;
  logic [1:0] slot_p0;

  assign same_p0     = (comm_p0 == cur_comm) && (font_p0 == cur_font);
  assign entry_valid = comm_is_valid(comm_p0);
  assign dec_p0      = seg_decode(font_p0[6:0]);
  assign slot_p0     = comm_slot(comm_p0);
  assign frame_done  = (seen == 4'b1111);

  // take_entry re-applies the idle rules to the current sample. It is used
  // from idle, and whenever the sample that started the dwell goes away.
  always_comb begin
    take_entry = 1'b0;
    capture    = 1'b0;
    cnt_step   = 1'b0;
    case (state)
      S_WAIT:   take_entry = 1'b1;
      S_SETTLE: begin
        if (!same_p0)                take_entry = 1'b1;
        else if (stab_cnt == SC_LAST) capture   = 1'b1;
        else                          cnt_step  = 1'b1;
      end
      S_HELD:   take_entry = !same_p0;
      S_BAD:    take_entry = (comm_p0 != cur_comm);
      default:  take_entry = 1'b1;
    endcase
    // With a one-sample filter, the entering sample is already stable.
    if (SINGLE && take_entry && entry_valid) capture = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_WAIT;
      stab_cnt   <= '0;
      cur_comm   <= COMM_BLANK;
      cur_font   <= FONT_BLANK;
      slot_digit <= '0;
      slot_dp    <= '0;
      slot_err   <= '0;
      seen       <= '0;
      o_err_cnt  <= '0;
    end else begin
      if (take_entry) begin
        cur_comm <= comm_p0;
        cur_font <= font_p0;
        stab_cnt <= SC_ONE;
        if (comm_p0 == COMM_BLANK) begin
          state <= S_WAIT;
        end else if (entry_valid) begin
          state <= SINGLE ? S_HELD : S_SETTLE;
        end else begin
          state <= S_BAD;
          if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
        end
      end else if (capture) begin
        state <= S_HELD;
      end else if (cnt_step) begin
        stab_cnt <= stab_cnt + SC_ONE;
      end

      if (capture) begin
        slot_digit[slot_p0] <= dec_p0[3:0];
        slot_dp[slot_p0]    <= ~font_p0[7];
        slot_err[slot_p0]   <= dec_p0[4];
      end

      // The output stage copies the slots on the cycle after completion.
      // A capture in that same cycle starts the next frame.
      seen <= (frame_done ? 4'b0000 : seen) | (capture ? ~comm_p0 : 4'b0000);
    end
  end

  // ---- stage p2: frame outputs and staleness timer ------------------------
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_frame_valid <= 1'b0;
      o_digits      <= '0;
      o_dp          <= '0;
      o_seg_err     <= '0;
      to_cnt        <= '0;
    end else begin
      o_frame_valid <= frame_done;
      if (frame_done) begin
        o_digits  <= slot_digit;
        o_dp      <= slot_dp;
        o_seg_err <= slot_err;
        to_cnt    <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  assign o_stale = (to_cnt == TO_MAX);

`ifdef BIN_OUT_EN
  function automatic logic [6:0] bcd_pair(input logic [3:0] hi, input logic [3:0] lo,
                                          input logic bad);
    return bad ? 7'h7F : (({3'd0, hi} * 7'd10) + {3'd0, lo});
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_bin_hi <= '0;
      o_bin_lo <= '0;
    end else if (frame_done) begin
      o_bin_hi <= bcd_pair(slot_digit[3], slot_digit[2], slot_err[3] | slot_err[2]);
      o_bin_lo <= bcd_pair(slot_digit[1], slot_digit[0], slot_err[1] | slot_err[0]);
    end
  end
`else
  assign o_bin_hi = 7'd0;
  assign o_bin_lo = 7'd0;
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
module tb_fnd_scan_decoder;

  logic        clk;
  logic        reset;
  logic [3:0]  comm;
  logic [7:0]  font;
  logic        frame_valid;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  seg_err;
  logic [7:0]  err_cnt;
  logic        stale;
  logic [6:0]  bin_hi;
  logic [6:0]  bin_lo;

  int checks = 0;
  int errors = 0;

  // Frame monitor, updated just after each rising edge.
  int pulses = 0;
  int cyc = 0;
  int last_pulse_cyc = 0;
  logic prev_stale = 1'b0;
  logic stale_before_pulse = 1'b0;
  logic stale_at_pulse = 1'b0;

  fnd_scan_decoder #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_fnd_comm   (comm),
    .i_fnd_font   (font),
    .o_frame_valid(frame_valid),
    .o_digits     (digits),
    .o_dp         (dp),
    .o_seg_err    (seg_err),
    .o_err_cnt    (err_cnt),
    .o_stale      (stale),
    .o_bin_hi     (bin_hi),
    .o_bin_lo     (bin_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (frame_valid === 1'b1) begin
      pulses = pulses + 1;
      last_pulse_cyc = cyc;
      stale_before_pulse = prev_stale;
      stale_at_pulse = stale;
    end
    prev_stale = stale;
  end

  task automatic drive(input logic [3:0] c, input logic [7:0] f, input int n);
    repeat (n) begin
      @(negedge clk);
      comm = c;
      font = f;
    end
  endtask

  // Fonts given most-significant digit first; 10-cycle dwells, then blank.
  task automatic scan4(input logic [7:0] f3, input logic [7:0] f2,
                       input logic [7:0] f1, input logic [7:0] f0);
    drive(4'b1110, f0, 10);
    drive(4'b1101, f1, 10);
    drive(4'b1011, f2, 10);
    drive(4'b0111, f3, 10);
    drive(4'b1111, 8'hFF, 4);
  endtask

  task automatic test_reset;
    int base;
    base = pulses;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      comm = 4'($urandom);
      font = 8'($urandom);
    end
    @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h expected 0000", digits); end
    checks++; if (dp !== 4'h0) begin errors++; $display("FAIL reset_dp: got %b expected 0000", dp); end
    checks++; if (seg_err !== 4'h0) begin errors++; $display("FAIL reset_seg_err: got %b expected 0000", seg_err); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL reset_stale: got %b expected 0", stale); end
    checks++; if (bin_hi !== 7'd0 || bin_lo !== 7'd0) begin errors++; $display("FAIL reset_bin: got %0d/%0d expected 0/0", bin_hi, bin_lo); end
    checks++; if (pulses != base) begin errors++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", pulses - base); end
    comm = 4'b1111;
    font = 8'hFF;
    reset = 1'b1;
    drive(4'b1111, 8'hFF, 3);
  endtask

  task automatic test_normal_scan;
    int base;
    base = pulses;
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99);
    checks++; if (pulses - base != 1) begin errors++; $display("FAIL normal_pulses: got %0d expected 1", pulses - base); end
    checks++; if (digits !== 16'h1234) begin errors++; $display("FAIL normal_digits: got %h expected 1234", digits); end
    checks++; if (seg_err !== 4'b0000) begin errors++; $display("FAIL normal_seg_err: got %b expected 0000", seg_err); end
    checks++; if (dp !== 4'b0000) begin errors++; $display("FAIL normal_dp: got %b expected 0000", dp); end
`ifdef BIN_OUT_EN
    checks++; if (bin_hi !== 7'd12 || bin_lo !== 7'd34) begin errors++; $display("FAIL normal_bin: got %0d/%0d expected 12/34", bin_hi, bin_lo); end
`else
    checks++; if (bin_hi !== 7'd0 || bin_lo !== 7'd0) begin errors++; $display("FAIL normal_bin_tied: got %0d/%0d expected 0/0", bin_hi, bin_lo); end
`endif
  endtask

  // Digit1 is scanned last, so a captured glitch would complete a wrong frame.
  task automatic test_glitch_filter;
    int base;
    base = pulses;
    drive(4'b1110, 8'h99, 10);
    drive(4'b1011, 8'hA4, 10);
    drive(4'b0111, 8'hF9, 10);
    drive(4'b1101, 8'h00, 2);
    drive(4'b1101, 8'h30, 10);
    drive(4'b1111, 8'hFF, 4);
    checks++; if (pulses - base != 1) begin errors++; $display("FAIL glitch_pulses: got %0d expected 1", pulses - base); end
    checks++; if (digits !== 16'h1234) begin errors++; $display("FAIL glitch_digits: got %h expected 1234", digits); end
    checks++; if (dp !== 4'b0010) begin errors++; $display("FAIL glitch_dp: got %b expected 0010", dp); end
  endtask

  task automatic test_invalid;
    int base;
    base = pulses;
    drive(4'b1100, 8'h99, 10);
    drive(4'b1111, 8'hFF, 3);
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL invalid_err_cnt: got %0d expected 1", err_cnt); end
    checks++; if (pulses != base) begin errors++; $display("FAIL invalid_no_frame: got %0d pulses expected 0", pulses - base); end
    scan4(8'h92, 8'h82, 8'hF8, 8'hFF);
    checks++; if (digits !== 16'h567F) begin errors++; $display("FAIL badfont_digits: got %h expected 567f", digits); end
    checks++; if (seg_err !== 4'b0001) begin errors++; $display("FAIL badfont_seg_err: got %b expected 0001", seg_err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL badfont_err_cnt: got %0d expected 1", err_cnt); end
`ifdef BIN_OUT_EN
    checks++; if (bin_hi !== 7'd56 || bin_lo !== 7'h7F) begin errors++; $display("FAIL badfont_bin: got %0d/%h expected 56/7f", bin_hi, bin_lo); end
`endif
  endtask

  task automatic test_timeout;
    int n;
    bit found;
    found = 1'b0;
    n = 0;
    comm = 4'b1111;
    font = 8'hFF;
    while (!found && n < 300) begin
      @(negedge clk);
      n++;
      if (stale === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL timeout_wait: stale=%b after %0d cycles, expected 1", stale, n); end
    checks++; if (cyc - last_pulse_cyc != 100) begin errors++; $display("FAIL timeout_cycle: stale after %0d cycles expected 100", cyc - last_pulse_cyc); end
    scan4(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    checks++; if (digits !== 16'h0123) begin errors++; $display("FAIL timeout_digits: got %h expected 0123", digits); end
    checks++; if (stale_before_pulse !== 1'b1) begin errors++; $display("FAIL stale_before_pulse: got %b expected 1", stale_before_pulse); end
    checks++; if (stale_at_pulse !== 1'b0) begin errors++; $display("FAIL stale_at_pulse: got %b expected 0", stale_at_pulse); end
  endtask

  task automatic test_dp;
    scan4(8'h80, 8'h24, 8'hC0, 8'hF9);
    checks++; if (digits !== 16'h8201) begin errors++; $display("FAIL dp_digits: got %h expected 8201", digits); end
    checks++; if (dp !== 4'b0100) begin errors++; $display("FAIL dp_bits: got %b expected 0100", dp); end
  endtask

  task automatic test_mid_reset;
    int base;
    base = pulses;
    drive(4'b1110, 8'h99, 10);
    drive(4'b1101, 8'hB0, 10);
    @(negedge clk);
    reset = 1'b0;
    comm = 4'b1111;
    font = 8'hFF;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL midreset_digits: got %h expected 0000", digits); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL midreset_err_cnt: got %0d expected 0", err_cnt); end
    drive(4'b1011, 8'hA4, 10);
    drive(4'b0111, 8'hF9, 10);
    drive(4'b1111, 8'hFF, 4);
    checks++; if (pulses != base) begin errors++; $display("FAIL midreset_partial: got %0d pulses expected 0", pulses - base); end
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99);
    checks++; if (pulses - base != 1) begin errors++; $display("FAIL midreset_rescan: got %0d pulses expected 1", pulses - base); end
    checks++; if (digits !== 16'h1234) begin errors++; $display("FAIL midreset_digits_after: got %h expected 1234", digits); end
  endtask

  initial begin
    reset = 1'b0;
    comm  = 4'b1111;
    font  = 8'hFF;
    test_reset();
    test_normal_scan();
    test_glitch_filter();
    test_invalid();
    test_timeout();
    test_dp();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
